// File: rtl/frame_transmit.sv
// Framed 24-bit word transmitter: HEAD0, HEAD1, then data bytes MSB first, over a UART start/done handshake.
// Define FRAME_CHECKSUM_EN to append a mod-256 checksum byte of the three data bytes.
module frame_transmit #(
  parameter logic [7:0]  HEAD0       = 8'hFF,
  parameter logic [7:0]  HEAD1       = 8'hAB,
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send_go,
  input  logic [23:0] send_data,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        send_done,
  output logic        send_err
);

`ifdef FRAME_CHECKSUM_EN
  localparam logic [2:0] LAST = 3'd5;
`else
  localparam logic [2:0] LAST = 3'd4;
`endif

  localparam int unsigned TW =
    (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned TLIM_I =
    (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [TW-1:0] TLIM = TLIM_I[TW-1:0];
  localparam logic [TW-1:0] TMAX = '1;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [23:0]   word_q, word_d;
  logic [7:0]    byte_q, byte_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          timeout;

  function automatic logic [7:0] pick(
    input logic [2:0]  i,
    input logic [23:0] w
  );
    logic [7:0] b;
    b = 8'h00;
    case (i)
      3'd0: b = HEAD0;
      3'd1: b = HEAD1;
      3'd2: b = w[23:16];
      3'd3: b = w[15:8];
      3'd4: b = w[7:0];
`ifdef FRAME_CHECKSUM_EN
      3'd5: b = w[23:16] + w[15:8] + w[7:0];
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Timer counts cycles since the current tx_start.
  assign timeout = TO_EN && (timer_q >= TLIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (send_go) state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        if (tx_done)
          state_d = (idx_q == LAST) ? IDLE : START;
        else if (timeout)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    timer_d = timer_q;
    word_d  = word_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (send_go) begin
          word_d  = send_data;
          idx_d   = '0;
          byte_d  = HEAD0;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q != TMAX) timer_d = timer_q + 1'b1;
      end
      WAIT: begin
        if (tx_done) begin
          if (idx_q == LAST) begin
            done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            byte_d  = pick(idx_q + 3'd1, word_q);
            timer_d = '0;
          end
        end else if (timeout) begin
          err_d = 1'b1;
        end else if (timer_q != TMAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    tx_start  = (state_q == START);
    busy      = (state_q != IDLE);
    tx_byte   = byte_q;
    send_done = done_q;
    send_err  = err_q;
  end

endmodule
